conv_operand_feeder: RTL
========================

// Module: conv_operand_feeder
// PURPOSE
//  Initiator side of the MAC operand protocol: walks every KxK stride-1 window of an IMG_W x IMG_W
//  int8 feature map, reads fmap and weight RAMs, and streams signed operand pairs into the MAC
//  (conv_a/conv_b/conv_start/compute_clear). Harvests each completed window sum, presented on
//  conv_result during a compute_clear cycle, and emits one result per output pixel, raster order.
// PARAMETERS
//  KSIZE    3   kernel side; taps per window = KSIZE*KSIZE
//  IMG_W    8   feature-map side; OUT_W = IMG_W-KSIZE+1; windows = OUT_W*OUT_W
//  FADDR_W  6   fmap address width (>= clog2(IMG_W*IMG_W))
//  WADDR_W  4   weight address width (>= clog2(KSIZE*KSIZE))
// PORTS
//  clk            in   1        clock
//  rst_n          in   1        async active-low reset
//  start          in   1        1-cycle job request; ignored unless IDLE
//  cfg_mode       in   1        MAC multiplier mode, forwarded on state_c1
//  busy           out  1        high from the cycle after accepted start to done (inclusive)
//  done           out  1        1-cycle pulse, job complete
//  fmap_addr      out  FADDR_W  (orow+kr)*IMG_W + (ocol+kc)
//  fmap_rdata     in   8 s      sync RAM, data valid 1 cycle after address
//  wgt_addr       out  WADDR_W  kr*KSIZE + kc
//  wgt_rdata      in   8 s      sync RAM, 1-cycle latency
//  conv_start     out  1        1-cycle pulse: MAC accumulator clear (MAC edge-detects, 2-cycle lag)
//  compute_clear  out  1        marks first product of a window / harvest cycle
//  state_c1       out  1        = cfg_mode latched at start
//  conv_a/conv_b  out  8 s      operands = fmap_rdata / wgt_rdata while valid, else 0
//  conv_result    in   32 s     MAC running sum; valid when compute_clear=1
//  res_valid      out  1        1-cycle pulse per window result
//  res_data       out  32 s     window sum (post-ReLU if enabled)
//  res_idx        out  16       output pixel index orow*OUT_W+ocol
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; counters cleared. Reset mid-job aborts, no done.
//  FSM: IDLE -start-> PRIME (2 cycles; conv_start=1 in first only) -> STREAM -> DRAIN -> DONE -> IDLE.
//  STREAM: one tap per cycle; kc innermost, then kr, then ocol, then orow; no bubbles.
//  Pipeline: S0 address issue; S1 operands driven (RAM data), tap_valid/first_tap delayed 1;
//   S2 product in MAC register; compute_clear = S2 first_tap flag, registered output.
//  Harvest: in a compute_clear cycle where >=1 window has completed, register conv_result ->
//   res_data, res_valid=1 next cycle, res_idx = index of completed window. First clear of a job
//   (window 0 start) produces no result.
//  DRAIN: after last tap issued, inject a phantom first_tap marker with tap_valid=0 (operands 0);
//   its compute_clear harvests the final window; S1/S2 flushed; then DONE (done=1, 1 cycle).
//  Timing (start at cycle 0): first addr cycle 3; window w first addr 3+w*K*K; its clear at +2;
//   result of window w valid at 3+(w+1)*K*K+3; done the cycle after the final res_valid.
//  Arithmetic: all signed; conv_result passed as-is (32b, MAC owns overflow).
//  Simultaneous start during busy: ignored. cfg_mode sampled only at accepted start.
// CONFIGURATION
//  FEEDER_RELU_EN defined: res_data = (conv_result<0) ? 0 : conv_result.
//  Undefined: res_data = conv_result unmodified. Timing identical either way.
// STRUCTURE
//  Package conv_pkg: state enum (IDLE,PRIME,STREAM,DRAIN,DONE), OUT_W/TAPS localparam helpers,
//  MAC operand/result width constants (8/32). One sub-module: conv_window_addr_gen (kc/kr/ocol/
//  orow counters, address math, first_tap/last_tap flags); FSM + pipeline + harvest in top.
// TESTING (KSIZE=3, IMG_W=4 -> 4 windows, 9 taps, 1-cycle RAM model)
//  1 all fmap=1, wgt=1, start@0 -> conv_start@1; res_valid@15,24,33,42 data=9 idx 0..3; done@43.
//  2 fmap=-128, wgt=-128 -> every res_data=147456; state_c1 = cfg_mode held whole job.
//  3 fmap[i]=i, wgt=1 -> res_data 45,54,81,90 (window sums), idx 0,1,2,3.
//  4 fmap=1, wgt=-1 -> res_data=-9 without FEEDER_RELU_EN; 0 with it.
//  5 start pulsed while busy -> ignored, exactly 4 results, one done; back-to-back job after done ok.
//  6 rst_n low mid-STREAM -> all outputs 0 same cycle, no done; fresh start runs test 1 timing.

Source files
------------

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and sizing helpers for the conv operand feeder
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } feeder_state_e;

  localparam int OPND_W = 8;
  localparam int RES_W  = 32;

  function automatic int calc_out_w(input int img_w, input int ksize);
    return img_w - ksize + 1;
  endfunction

  function automatic int calc_taps(input int ksize);
    return ksize * ksize;
  endfunction

endpackage

// File: rtl/conv_window_addr_gen.sv
// rtl/conv_window_addr_gen.sv - window/tap counters and fmap/weight address generation
module conv_window_addr_gen
  import conv_pkg::*;
#(
  parameter int KSIZE   = 3,
  parameter int IMG_W   = 8,
  parameter int FADDR_W = 6,
  parameter int WADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               adv,
  output logic [FADDR_W-1:0] fmap_addr,
  output logic [WADDR_W-1:0] wgt_addr,
  output logic               first_tap,
  output logic               last_tap
);

  localparam int OUT_W = calc_out_w(IMG_W, KSIZE);
  localparam int KW    = $clog2(KSIZE + 1);
  localparam int OW    = $clog2(OUT_W + 1);

  logic [KW-1:0] kc_q, kc_d, kr_q, kr_d;
  logic [OW-1:0] ocol_q, ocol_d, orow_q, orow_d;
  logic          kc_last, kr_last, ocol_last, orow_last;

  assign kc_last   = (kc_q == KW'(KSIZE - 1));
  assign kr_last   = (kr_q == KW'(KSIZE - 1));
  assign ocol_last = (ocol_q == OW'(OUT_W - 1));
  assign orow_last = (orow_q == OW'(OUT_W - 1));

  assign first_tap = (kc_q == '0) && (kr_q == '0);
  assign last_tap  = kc_last && kr_last && ocol_last && orow_last;

  assign fmap_addr = FADDR_W'((int'(orow_q) + int'(kr_q)) * IMG_W + int'(ocol_q) + int'(kc_q));
  assign wgt_addr  = WADDR_W'(int'(kr_q) * KSIZE + int'(kc_q));

  // Nested counters: kc innermost, then kr, ocol, orow; the final wrap returns all to zero
  always_comb begin
    kc_d   = kc_q;
    kr_d   = kr_q;
    ocol_d = ocol_q;
    orow_d = orow_q;
    if (clr) begin
      kc_d   = '0;
      kr_d   = '0;
      ocol_d = '0;
      orow_d = '0;
    end else if (adv) begin
      if (!kc_last) begin
        kc_d = kc_q + KW'(1);
      end else begin
        kc_d = '0;
        if (!kr_last) begin
          kr_d = kr_q + KW'(1);
        end else begin
          kr_d = '0;
          if (!ocol_last) begin
            ocol_d = ocol_q + OW'(1);
          end else begin
            ocol_d = '0;
            orow_d = orow_last ? '0 : orow_q + OW'(1);
          end
        end
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kc_q   <= '0;
      kr_q   <= '0;
      ocol_q <= '0;
      orow_q <= '0;
    end else begin
      kc_q   <= kc_d;
      kr_q   <= kr_d;
      ocol_q <= ocol_d;
      orow_q <= orow_d;
    end
  end

endmodule

// File: rtl/conv_operand_feeder.sv
// rtl/conv_operand_feeder.sv - MAC operand streamer and window-result harvester (option: FEEDER_RELU_EN)
module conv_operand_feeder
  import conv_pkg::*;
#(
  parameter int KSIZE   = 3,
  parameter int IMG_W   = 8,
  parameter int FADDR_W = 6,
  parameter int WADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     cfg_mode,
  output logic                     busy,
  output logic                     done,
  output logic [FADDR_W-1:0]       fmap_addr,
  input  logic signed [OPND_W-1:0] fmap_rdata,
  output logic [WADDR_W-1:0]       wgt_addr,
  input  logic signed [OPND_W-1:0] wgt_rdata,
  output logic                     conv_start,
  output logic                     compute_clear,
  output logic                     state_c1,
  output logic signed [OPND_W-1:0] conv_a,
  output logic signed [OPND_W-1:0] conv_b,
  input  logic signed [RES_W-1:0]  conv_result,
  output logic                     res_valid,
  output logic signed [RES_W-1:0]  res_data,
  output logic [15:0]              res_idx
);

  feeder_state_e state_q, state_d;
  logic [1:0]    phase_q, phase_d;
  logic          mode_q, mode_d;
  logic          tap_valid_s1_q, tap_valid_s1_d;
  logic          first_s1_q, first_s1_d;
  logic          compute_clear_q, compute_clear_d;
  logic          win_seen_q, win_seen_d;
  logic [15:0]   harv_idx_q, harv_idx_d;
  logic          res_valid_q, res_valid_d;
  logic signed [RES_W-1:0] res_data_q, res_data_d;
  logic [15:0]   res_idx_q, res_idx_d;

  logic gen_clr, gen_adv, s0_valid, s0_first, job_start;
  logic first_tap, last_tap;

  conv_window_addr_gen #(
    .KSIZE  (KSIZE),
    .IMG_W  (IMG_W),
    .FADDR_W(FADDR_W),
    .WADDR_W(WADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (gen_clr),
    .adv      (gen_adv),
    .fmap_addr(fmap_addr),
    .wgt_addr (wgt_addr),
    .first_tap(first_tap),
    .last_tap (last_tap)
  );

  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign conv_start    = (state_q == ST_PRIME) && (phase_q == 2'd0);
  assign state_c1      = mode_q;
  assign compute_clear = compute_clear_q;
  assign conv_a        = tap_valid_s1_q ? fmap_rdata : '0;
  assign conv_b        = tap_valid_s1_q ? wgt_rdata : '0;
  assign res_valid     = res_valid_q;
  assign res_data      = res_data_q;
  assign res_idx       = res_idx_q;

  // Job sequencing; DRAIN issues the phantom first-tap marker, then waits out the 4-cycle flush
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    mode_d    = mode_q;
    gen_clr   = 1'b0;
    gen_adv   = 1'b0;
    s0_valid  = 1'b0;
    s0_first  = 1'b0;
    job_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_PRIME;
          phase_d   = 2'd0;
          mode_d    = cfg_mode;
          gen_clr   = 1'b1;
          job_start = 1'b1;
        end
      end
      ST_PRIME: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd1) begin
          state_d = ST_STREAM;
          phase_d = 2'd0;
        end
      end
      ST_STREAM: begin
        gen_adv  = 1'b1;
        s0_valid = 1'b1;
        s0_first = first_tap;
        if (last_tap) begin
          state_d = ST_DRAIN;
          phase_d = 2'd0;
        end
      end
      ST_DRAIN: begin
        phase_d  = phase_q + 2'd1;
        s0_first = (phase_q == 2'd0);
        if (phase_q == 2'd3) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Operand pipeline flags and result harvest; the first clear of a job has nothing to harvest
  always_comb begin
    tap_valid_s1_d  = s0_valid;
    first_s1_d      = s0_first;
    compute_clear_d = first_s1_q;
    win_seen_d      = win_seen_q;
    harv_idx_d      = harv_idx_q;
    res_valid_d     = 1'b0;
    res_data_d      = res_data_q;
    res_idx_d       = res_idx_q;
    if (job_start) begin
      win_seen_d = 1'b0;
      harv_idx_d = '0;
    end else if (compute_clear_q) begin
      win_seen_d = 1'b1;
      if (win_seen_q) begin
        res_valid_d = 1'b1;
        res_idx_d   = harv_idx_q;
        harv_idx_d  = harv_idx_q + 16'd1;
`ifdef FEEDER_RELU_EN
        res_data_d  = conv_result[RES_W-1] ? '0 : conv_result;
`else
        res_data_d  = conv_result;
`endif
      end
    end
  end

  // State, pipeline and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      phase_q         <= '0;
      mode_q          <= 1'b0;
      tap_valid_s1_q  <= 1'b0;
      first_s1_q      <= 1'b0;
      compute_clear_q <= 1'b0;
      win_seen_q      <= 1'b0;
      harv_idx_q      <= '0;
      res_valid_q     <= 1'b0;
      res_data_q      <= '0;
      res_idx_q       <= '0;
    end else begin
      state_q         <= state_d;
      phase_q         <= phase_d;
      mode_q          <= mode_d;
      tap_valid_s1_q  <= tap_valid_s1_d;
      first_s1_q      <= first_s1_d;
      compute_clear_q <= compute_clear_d;
      win_seen_q      <= win_seen_d;
      harv_idx_q      <= harv_idx_d;
      res_valid_q     <= res_valid_d;
      res_data_q      <= res_data_d;
      res_idx_q       <= res_idx_d;
    end
  end

endmodule
